nco_clk_enable_gen: RTL and testbench

// Generalised successor to fixed-ratio PLL clock outputs: derives NUM_CH independent

---
 rtl/nco_clk_enable_gen.sv | 98 +++++++++
 tb/tb_nco_clk_enable_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/nco_clk_enable_gen.sv
// Multi-channel NCO clock-enable generator: each channel's phase accumulator
// carry becomes a one-cycle enable, with a PLL-style settle/locked indication.
module nco_clk_enable_gen #(
  parameter int unsigned                NUM_CH        = 3,
  parameter int unsigned                ACC_W         = 32,
  parameter int unsigned                CH_W          = 4,
  parameter int unsigned                LOCK_CYCLES   = 16,
  parameter bit                         GATE_UNLOCKED = 1'b1,
  parameter logic [NUM_CH*ACC_W-1:0]    DEFAULT_INC   = '0,
  parameter logic [NUM_CH*ACC_W-1:0]    DEFAULT_PHASE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic              sync,
  output logic [NUM_CH-1:0] en_out,
  output logic              locked
);

  localparam int unsigned CNT_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic {SETTLE, LOCKED} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [NUM_CH-1:0] en_r;
  logic              accept, ch_ok, restart;

  assign cfg_ready = (state == LOCKED) & reset_n;
  assign accept    = cfg_valid & cfg_ready;
  assign ch_ok     = 32'(cfg_ch) < NUM_CH;
  assign restart   = (accept & ch_ok) | sync;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (restart) begin
      state_nxt = SETTLE;
      cnt_nxt   = CNT_W'(LOCK_CYCLES);
    end else if (state == SETTLE) begin
      if (cnt <= CNT_W'(1)) begin
        cnt_nxt   = '0;
        state_nxt = LOCKED;
      end else begin
        cnt_nxt = cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= SETTLE;
      cnt   <= CNT_W'(LOCK_CYCLES);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] inc_r, ph_r, acc;
    logic [ACC_W:0]   sum;
    logic             en_q, wr;

    assign sum     = {1'b0, acc} + {1'b0, inc_r};
    assign wr      = accept & (32'(cfg_ch) == i);
    assign en_r[i] = en_q;

    // A write to this channel takes priority over sync so the fresh phase wins.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        inc_r <= DEFAULT_INC[i*ACC_W +: ACC_W];
        ph_r  <= DEFAULT_PHASE[i*ACC_W +: ACC_W];
        acc   <= DEFAULT_PHASE[i*ACC_W +: ACC_W];
        en_q  <= 1'b0;
      end else if (wr) begin
        inc_r <= cfg_inc;
        ph_r  <= cfg_phase;
        acc   <= cfg_phase;
        en_q  <= 1'b0;
      end else if (sync) begin
        acc   <= ph_r;
        en_q  <= 1'b0;
      end else begin
        acc   <= sum[ACC_W-1:0];
        en_q  <= sum[ACC_W];
      end
    end
  end

  assign locked = (state == LOCKED);
  assign en_out = (GATE_UNLOCKED && (state != LOCKED)) ? '0 : en_r;

endmodule

// File: tb/tb_nco_clk_enable_gen.sv
// Directed bench: one ungated and one gated instance driven in lockstep,
// expected pulse patterns derived by hand from accumulator arithmetic.
module tb_nco_clk_enable_gen;
  localparam int unsigned NUM_CH = 3;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned CH_W   = 4;
  localparam logic [NUM_CH*ACC_W-1:0] DEF_INC = {32'h0, 32'h0, 32'h4000_0000};
  localparam logic [NUM_CH*ACC_W-1:0] DEF_PH  = '0;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              sync = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [ACC_W-1:0]  cfg_inc = '0;
  logic [ACC_W-1:0]  cfg_phase = '0;
  logic              cfg_ready, locked, cfg_ready_g, locked_g;
  logic [NUM_CH-1:0] en_out, en_out_g;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;
  logic [2:0] e;

  always #5 clk = ~clk;

  nco_clk_enable_gen #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .CH_W(CH_W), .LOCK_CYCLES(16),
    .GATE_UNLOCKED(1'b0), .DEFAULT_INC(DEF_INC), .DEFAULT_PHASE(DEF_PH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .sync(sync),
    .en_out(en_out), .locked(locked)
  );

  nco_clk_enable_gen #(
    .NUM_CH(NUM_CH), .ACC_W(ACC_W), .CH_W(CH_W), .LOCK_CYCLES(16),
    .GATE_UNLOCKED(1'b1), .DEFAULT_INC(DEF_INC), .DEFAULT_PHASE(DEF_PH)
  ) dut_g (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_g),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .sync(sync),
    .en_out(en_out_g), .locked(locked_g)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic exp_locked, input logic [2:0] exp_en);
    check({tag, "_locked"}, 32'(locked), 32'(exp_locked));
    check({tag, "_ready"},  32'(cfg_ready), 32'(exp_locked));
    check({tag, "_en"},     32'(en_out), 32'(exp_en));
    check({tag, "_locked_g"}, 32'(locked_g), 32'(exp_locked));
    check({tag, "_en_g"},   32'(en_out_g), exp_locked ? 32'(exp_en) : 32'd0);
  endtask

  initial begin
    // Reset held for a few edges
    repeat (3) tick();
    check_outs("reset", 1'b0, 3'b000);

    // Release: ch0 inc 2^30 from phase 0 wraps every 4th edge; lock after 16
    reset_n = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      e = {1'b0, 1'b0, (k % 4 == 0)};
      check_outs("rel", (k >= 16), e);
    end

    // Write ch1 inc=2^31 phase=2^31 while locked (edge 21)
    cfg_valid = 1'b1; cfg_ch = 4'd1; cfg_inc = 32'h8000_0000; cfg_phase = 32'h8000_0000;
    check("wr1_ready_pre", 32'(cfg_ready), 32'd1);
    tick();
    cfg_valid = 1'b0;
    check_outs("wr1_edge", 1'b0, 3'b000);
    for (int j = 1; j <= 16; j++) begin
      tick();
      e = {1'b0, (j % 2 == 1), (cyc % 4 == 0)};
      check_outs("wr1", (j >= 16), e);
    end

    // Out-of-range channel: handshake only
    cfg_valid = 1'b1; cfg_ch = 4'd5; cfg_inc = 32'h1234_5678; cfg_phase = 32'h9abc_def0;
    check("bad_ch_ready_pre", 32'(cfg_ready), 32'd1);
    for (int j = 1; j <= 4; j++) begin
      tick();
      cfg_valid = 1'b0;
      e = {1'b0, (cyc % 2 == 0), (cyc % 4 == 0)};
      check_outs("bad_ch", 1'b1, e);
    end

    // ch2 inc=0x55555556: 3072 edges sum to 1024*2^32 + 2048 -> exactly 1024 carries
    cfg_valid = 1'b1; cfg_ch = 4'd2; cfg_inc = 32'h5555_5556; cfg_phase = 32'h0;
    tick();
    cfg_valid = 1'b0;
    pulses = 0;
    for (int n = 1; n <= 3072; n++) begin
      tick();
      if (en_out[2]) pulses++;
      if (n <= 20) begin
        e = {(n % 3 == 0), (cyc % 2 == 0), (cyc % 4 == 0)};
        check_outs("ch2_run", (n >= 16), e);
      end
    end
    check("ch2_pulse_count", 32'(pulses), 32'd1024);

    // sync mid-run: all channels realign to phases 0 / 2^31 / 0
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check_outs("sync_edge", 1'b0, 3'b000);
    for (int j = 1; j <= 7; j++) begin
      tick();
      e = {(j % 3 == 0), (j % 2 == 1), (j % 4 == 0)};
      check_outs("sync1", 1'b0, e);
    end
    // Second sync at relative edge 8 restarts the settle counter
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check_outs("sync2_edge", 1'b0, 3'b000);
    for (int j = 1; j <= 16; j++) begin
      tick();
      e = {(j % 3 == 0), (j % 2 == 1), (j % 4 == 0)};
      check_outs("sync2", (j >= 16), e);
      if (j == 9) begin
        // Write raised during settle must be held off until locked
        cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_inc = 32'h2000_0000; cfg_phase = 32'h0;
      end
    end
    tick();
    cfg_valid = 1'b0;
    check_outs("held_wr_edge", 1'b0, 3'b010);
    for (int k = 1; k <= 16; k++) begin
      tick();
      e = {((17 + k) % 3 == 0), ((17 + k) % 2 == 1), (k % 8 == 0)};
      check_outs("held_wr", (k >= 16), e);
    end

    // Reset mid-settle after a cfg write restores defaults
    cfg_valid = 1'b1; cfg_ch = 4'd1; cfg_inc = 32'h1000_0000; cfg_phase = 32'h0000_1234;
    tick();
    cfg_valid = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    check_outs("rst2_hold", 1'b0, 3'b000);
    reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      e = {1'b0, 1'b0, (k % 4 == 0)};
      check_outs("rst2", (k >= 16), e);
    end

    // sync and accept on the same edge: ch2 starts from the new phase
    cfg_valid = 1'b1; cfg_ch = 4'd2; cfg_inc = 32'h8000_0000; cfg_phase = 32'h8000_0000;
    sync = 1'b1;
    tick();
    cfg_valid = 1'b0;
    sync = 1'b0;
    check_outs("sync_acc_edge", 1'b0, 3'b000);
    for (int j = 1; j <= 8; j++) begin
      tick();
      e = {(j % 2 == 1), 1'b0, (j % 4 == 0)};
      check_outs("sync_acc", 1'b0, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
